// File: rtl/ramb4_s2_arbiter.sv
// Round-robin arbiter for two requesters sharing a 2048x2 block RAM, with optional clear sweep.
// The clear engine is compiled in only when RAMB_ARB_CLEAR_EN is defined.
module ramb4_s2_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_A,
    input  logic        REQ_B,
    input  logic        WE_A,
    input  logic        WE_B,
    input  logic [10:0] ADDR_A,
    input  logic [10:0] ADDR_B,
    input  logic [1:0]  DI_A,
    input  logic [1:0]  DI_B,
    output logic        GNT_A,
    output logic        GNT_B,
    output logic        RVALID_A,
    output logic        RVALID_B,
    output logic [1:0]  DO_A,
    output logic [1:0]  DO_B,
    input  logic        CLR_START,
    input  logic [1:0]  CLR_VAL,
    output logic        CLR_BUSY,
    output logic        CLR_DONE,
    output logic        M_EN,
    output logic        M_WE,
    output logic [10:0] M_ADDR,
    output logic [1:0]  M_DI,
    input  logic [1:0]  M_DO
);

    // state | meaning
    // IDLE  | arbitrate between port A and port B
    // CLEAR | sweep every address with the latched clear value
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state, state_nxt;
    logic        ptr;            // 0 = A preferred on contention, 1 = B
    logic        rv_a_q, rv_b_q;
    logic        win_a;
    logic [10:0] cnt;
    logic [1:0]  clr_val_q;
    logic        clr_done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            rv_a_q <= 1'b0;
            rv_b_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rv_a_q <= GNT_A & ~WE_A;
            rv_b_q <= GNT_B & ~WE_B;
            if (GNT_A)
                ptr <= 1'b1;
            else if (GNT_B)
                ptr <= 1'b0;
        end
    end

`ifdef RAMB_ARB_CLEAR_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            clr_val_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= (state == CLEAR) && (cnt == 11'h7FF);
            if (state == IDLE && CLR_START) begin
                cnt       <= '0;
                clr_val_q <= CLR_VAL;
            end else if (state == CLEAR) begin
                cnt <= cnt + 11'd1;
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr = ^{CLR_START, CLR_VAL};
    assign cnt        = '0;
    assign clr_val_q  = '0;
    assign clr_done_q = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        win_a     = 1'b0;
        GNT_A     = 1'b0;
        GNT_B     = 1'b0;
        M_EN      = 1'b0;
        M_WE      = 1'b0;
        M_ADDR    = '0;
        M_DI      = '0;
        case (state)
            IDLE: begin
                win_a = REQ_A & (~REQ_B | ~ptr);
                GNT_A = win_a;
                GNT_B = REQ_B & ~win_a;
                if (GNT_A) begin
                    M_EN   = 1'b1;
                    M_WE   = WE_A;
                    M_ADDR = ADDR_A;
                    M_DI   = DI_A;
                end else if (GNT_B) begin
                    M_EN   = 1'b1;
                    M_WE   = WE_B;
                    M_ADDR = ADDR_B;
                    M_DI   = DI_B;
                end
`ifdef RAMB_ARB_CLEAR_EN
                if (CLR_START)
                    state_nxt = CLEAR;
`endif
            end
            CLEAR: begin
                M_EN   = 1'b1;
                M_WE   = 1'b1;
                M_ADDR = cnt;
                M_DI   = clr_val_q;
                if (cnt == 11'h7FF)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset blocks the RAM port immediately so an aborted sweep stops on the reset cycle.
        if (RST) begin
            GNT_A  = 1'b0;
            GNT_B  = 1'b0;
            M_EN   = 1'b0;
            M_WE   = 1'b0;
            M_ADDR = '0;
            M_DI   = '0;
        end
    end

    assign RVALID_A = rv_a_q & ~RST;
    assign RVALID_B = rv_b_q & ~RST;
    assign DO_A     = M_DO;
    assign DO_B     = M_DO;
    assign CLR_BUSY = (state == CLEAR);
    assign CLR_DONE = clr_done_q;

endmodule

// File: doc/ramb4_s2_arbiter.md
# ramb4_s2_arbiter

Two-port round-robin arbiter and clear sequencer in front of a single-port 2048 x 2 block RAM (RAMB4_S2 organisation: 11-bit address, 2-bit data, registered read data, write-first output). Two independent requesters share the RAM through request/grant handshakes, and read data returns one cycle after grant. An optional clear engine sweeps the whole array to a fixed value while holding off both requesters.

## Interface
- No parameters. Geometry is fixed at 2048 words x 2 bits.

Ports:
- CLK  in  1  single clock; all state updates on posedge
- RST  in  1  reset, synchronous and active-high
- REQ_A / REQ_B  in  1  access request per port
- WE_A / WE_B  in  1  1 = write, 0 = read; held with REQ
- ADDR_A / ADDR_B  in  11  word address; held with REQ
- DI_A / DI_B  in  2  write data; held with REQ
- GNT_A / GNT_B  out  1  combinational accept; the access is issued this cycle
- RVALID_A / RVALID_B  out  1  read data valid, one-cycle pulse
- DO_A / DO_B  out  2  read data; both driven from M_DO
- CLR_START  in  1  start full-array clear (single-cycle pulse)
- CLR_VAL  in  2  value written by the clear; sampled with CLR_START
- CLR_BUSY  out  1  clear in progress
- CLR_DONE  out  1  one-cycle pulse after the last clear write
- M_EN, M_WE  out  1  RAM enable and write enable
- M_ADDR  out  11  RAM address
- M_DI  out  2  RAM write data
- M_DO  in  2  RAM registered read data

The RAM's RST input is tied low at integration.

## Operation
- States:
  - IDLE: arbitrate between the two ports.
  - CLEAR: sweep the array.
- IDLE arbitration:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port selected by the priority pointer PTR wins.
  - GNT_x = REQ_x & win & (state == IDLE).
  - The granted port's WE/ADDR/DI drive M_WE/M_ADDR/M_DI, and M_EN = 1.
  - With no grant, M_EN = 0 and M_WE = 0.
- PTR update: after a grant to port p, PTR moves to the other port. With no grant, PTR holds.
- Requester rule: REQ and its qualifiers stay stable until GNT is seen high. The request is consumed on that edge.
- Read return: a read granted in cycle N asserts RVALID_x in cycle N+1, with DO_x = M_DO. Writes produce no RVALID.
- Clear start: CLR_START in IDLE latches CLR_VAL and moves to CLEAR on the next edge.
  - A request in the same cycle as CLR_START is still granted.
  - CLR_START is ignored in CLEAR.
- CLEAR: an 11-bit counter CNT starts at 0. Each cycle drives M_EN = 1, M_WE = 1, M_ADDR = CNT, M_DI = latched value, then increments CNT.
  - At CNT = 2047 the write is issued, CLR_DONE pulses the next cycle, and the state returns to IDLE.
  - The sweep totals exactly 2048 writes.
  - GNT_A and GNT_B are 0 throughout CLEAR, and pending requests wait.
- Reset values: state IDLE, PTR = A, CNT = 0, latched value 0, and every output 0 (RVALID_*, CLR_BUSY, CLR_DONE, M_EN, M_WE, M_ADDR, M_DI).
- Reset mid-clear: the sweep aborts, there is no CLR_DONE, and the array is left partially cleared.
- Reset one cycle after a read grant: RVALID is suppressed.

## Timing
- Grant is combinational from REQ and the registered state/PTR. There is no REQ-to-GNT register stage.
- Read latency is 1 cycle from GNT to RVALID. Throughput is one access per cycle, shared between ports.
- Back-to-back reads by alternating ports return in order, with one RVALID per cycle.
- CLR_BUSY:
  - Rises on the edge following CLR_START.
  - Stays high for 2048 cycles.
  - Falls in the same cycle CLR_DONE rises.
- Clear duration is 2048 cycles of CLEAR plus one CLR_DONE cycle. The first grant after a clear is possible in the CLR_DONE cycle.
- Starvation bound: a continuously requesting port is granted within 2 cycles in IDLE.

## Configuration
- RAMB_ARB_CLEAR_EN defined: the clear engine, CNT and the CLEAR state are compiled in, as described above.
- Not defined:
  - The state is permanently IDLE and CLR_START/CLR_VAL are ignored.
  - CLR_BUSY and CLR_DONE are tied 0.
  - The ports remain, so the interface is unchanged.

## Test plan
- Reset: RST high for 2 cycles, then low, with no requests. Every output is 0, M_EN = 0, and the first dual request grants A.
- Single port: A writes 2'b10 to 0x155, then A reads 0x155. GNT_A is high in both cycles, and RVALID_A = 1 with DO_A = 2'b10 one cycle after the read grant.
- Contention: REQ_A and REQ_B held high with reads to 0x001 and 0x002 (preloaded 01 and 11). Grants alternate A, B, A, B. RVALIDs alternate with DO 01, 11, and RVALID_B never coincides with RVALID_A.
- Clear: CLR_START with CLR_VAL = 2'b11 while REQ_B pends.
  - CLR_BUSY is high for 2048 cycles and GNT_B is 0 throughout.
  - CLR_DONE pulses once and GNT_B follows.
  - Reads of 0x000 and 0x7FF return 11.
- Reset mid-clear: RST at CNT = 100. No CLR_DONE and CLR_BUSY = 0 next cycle. Address 0x063 reads CLR_VAL and address 0x064 holds its old data.
- Macro off (RAMB_ARB_CLEAR_EN undefined): a CLR_START pulse changes nothing. CLR_BUSY stays 0 and grants continue uninterrupted.
